// File: rtl/codma_resp_pkg.sv
// Shared types and helpers for the CODMA bus responder.
package codma_resp_pkg;

  localparam int MAX_BURST_WORDS = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_RESP,
    WR_RESP,
    DONE
  } resp_state_t;

  // Burst size code to word count; codes above 3 are illegal and map to 0.
  function automatic logic [3:0] size_to_words(input logic [3:0] size);
    case (size)
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return 4'd4;
      4'd3:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/codma_bus_if.sv
// Burst read/write bus between the CODMA master and a memory responder.
interface codma_bus_if;
  import codma_resp_pkg::*;

  logic                             read_valid;
  logic                             write_valid;
  logic [31:0]                      addr;
  logic [3:0]                       size;
  logic [MAX_BURST_WORDS-1:0][31:0] write_data;
  logic                             read_ready;
  logic                             write_ready;
  logic [MAX_BURST_WORDS-1:0][31:0] read_data;
  logic                             error;

  modport master (
    output read_valid, write_valid, addr, size, write_data,
    input  read_ready, write_ready, read_data, error
  );

  modport slave (
    input  read_valid, write_valid, addr, size, write_data,
    output read_ready, write_ready, read_data, error
  );

endinterface

// File: rtl/codma_resp_mem.sv
// Word-addressed responder memory: 8-lane burst read, masked 8-lane burst
// write and a single-word backdoor write that loses to the burst write.
module codma_resp_mem
  import codma_resp_pkg::*;
#(
  parameter  int MEM_DEPTH_WORDS = 1024,
  localparam int AW              = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic                             clk_i,
  input  logic [AW-1:0]                    rd_idx_i,
  output logic [MAX_BURST_WORDS-1:0][31:0] rd_data_o,
  input  logic                             wr_en_i,
  input  logic [AW-1:0]                    wr_idx_i,
  input  logic [MAX_BURST_WORDS-1:0]       wr_mask_i,
  input  logic [MAX_BURST_WORDS-1:0][31:0] wr_data_i,
  input  logic                             bd_we_i,
  input  logic [AW-1:0]                    bd_idx_i,
  input  logic [31:0]                      bd_wdata_i
);

  logic [31:0] mem [MEM_DEPTH_WORDS];

  // Burst read lanes straight from the latched start index.
  always_comb begin
    for (int i = 0; i < MAX_BURST_WORDS; i++) begin
      rd_data_o[i] = mem[rd_idx_i + AW'(i)];
    end
  end

  // Backdoor first so a same-word burst write overrides it.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) begin
      mem[bd_idx_i] <= bd_wdata_i;
    end
    if (wr_en_i) begin
      for (int i = 0; i < MAX_BURST_WORDS; i++) begin
        if (wr_mask_i[i]) begin
          mem[wr_idx_i + AW'(i)] <= wr_data_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/codma_bus_responder.sv
// Bus responder: accepts CODMA burst requests, waits a programmable latency
// (freezable by stall_i), then returns a one-cycle ready pulse.
// Table of states:
//   IDLE    | waiting for read_valid / write_valid
//   RD_WAIT | read latency countdown
//   WR_WAIT | write latency countdown
//   RD_RESP | read_ready + read_data presented
//   WR_RESP | write_ready presented, memory written
//   DONE    | valid ignored so the master can drop it
module codma_bus_responder
  import codma_resp_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int RD_LATENCY      = 2,
  parameter int WR_LATENCY      = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  codma_bus_if.slave  bus_if,
  input  logic        stall_i,
  input  logic        bd_we_i,
  input  logic [31:0] bd_addr_i,
  input  logic [31:0] bd_wdata_i,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  resp_state_t                      state;
  logic [15:0]                      cnt;
  logic                             err_q;
  logic [AW-1:0]                    idx_q;
  logic [3:0]                       nwords_q;
  logic [MAX_BURST_WORDS-1:0][31:0] wdata_q;
  logic [MAX_BURST_WORDS-1:0]       lane_mask;
  logic [MAX_BURST_WORDS-1:0][31:0] mem_rd;
  logic [MAX_BURST_WORDS-1:0][31:0] rd_masked;
  logic [3:0]                       req_words;
  logic                             req_err;
  logic                             unused_bd_bits;

  // Only the word-index bits of the backdoor address select a location.
  assign unused_bd_bits = ^{bd_addr_i[31:AW+2], bd_addr_i[1:0]};

  // Request legality: size code, alignment, and no run past the top of memory.
  always_comb begin
    req_words = size_to_words(bus_if.size);
    req_err   = (bus_if.size > 4'd3) ||
                (bus_if.addr[1:0] != 2'b00) ||
                (({3'b000, bus_if.addr[31:2]} + 33'(req_words)) > 33'(MEM_DEPTH_WORDS));
  end

  // Lanes beyond the burst length are masked off for both read and write.
  always_comb begin
    lane_mask = '0;
    rd_masked = '0;
    for (int i = 0; i < MAX_BURST_WORDS; i++) begin
      lane_mask[i] = (4'(i) < nwords_q);
      rd_masked[i] = lane_mask[i] ? mem_rd[i] : 32'h0;
    end
  end

  codma_resp_mem #(
    .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS)
  ) u_mem (
    .clk_i      (clk_i),
    .rd_idx_i   (idx_q),
    .rd_data_o  (mem_rd),
    .wr_en_i    ((state == WR_RESP) && !err_q),
    .wr_idx_i   (idx_q),
    .wr_mask_i  (lane_mask),
    .wr_data_i  (wdata_q),
    .bd_we_i    (bd_we_i),
    .bd_idx_i   (bd_addr_i[AW+1:2]),
    .bd_wdata_i (bd_wdata_i)
  );

  // Request FSM with registered ready/data/error pulses and completion counters.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state              <= IDLE;
      cnt                <= '0;
      err_q              <= 1'b0;
      idx_q              <= '0;
      nwords_q           <= '0;
      wdata_q            <= '0;
      bus_if.read_ready  <= 1'b0;
      bus_if.write_ready <= 1'b0;
      bus_if.error       <= 1'b0;
      bus_if.read_data   <= '0;
      rd_count_o         <= '0;
      wr_count_o         <= '0;
    end else begin
      bus_if.read_ready  <= 1'b0;
      bus_if.write_ready <= 1'b0;
      bus_if.error       <= 1'b0;
      bus_if.read_data   <= '0;
      case (state)
        IDLE: begin
          if (bus_if.read_valid) begin
            idx_q    <= bus_if.addr[AW+1:2];
            nwords_q <= req_words;
            err_q    <= req_err || bus_if.write_valid;
            cnt      <= 16'(RD_LATENCY);
            state    <= RD_WAIT;
          end else if (bus_if.write_valid) begin
            idx_q    <= bus_if.addr[AW+1:2];
            nwords_q <= req_words;
            wdata_q  <= bus_if.write_data;
            err_q    <= req_err;
            cnt      <= 16'(WR_LATENCY);
            state    <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (!stall_i) begin
            if (cnt == 16'd0) begin
              state             <= RD_RESP;
              bus_if.read_ready <= 1'b1;
              bus_if.error      <= err_q;
              bus_if.read_data  <= err_q ? '0 : rd_masked;
              rd_count_o        <= rd_count_o + 16'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        WR_WAIT: begin
          if (!stall_i) begin
            if (cnt == 16'd0) begin
              state              <= WR_RESP;
              bus_if.write_ready <= 1'b1;
              bus_if.error       <= err_q;
              wr_count_o         <= wr_count_o + 16'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        RD_RESP, WR_RESP: state <= DONE;
        DONE:             state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codma_bus_responder.sv
// Self-checking bench for codma_bus_responder: scoreboarded burst traffic,
// latency, stall, error, collision and mid-operation reset scenarios.
module tb_codma_bus_responder;

  localparam int DEPTH = 1024;
  localparam int RDL   = 2;
  localparam int WRL   = 1;

  typedef struct {
    logic            is_rd;
    logic            err;
    logic [7:0][31:0] data;
    int              lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_wdata = '0;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] model [DEPTH];
  exp_t sb[$];

  codma_bus_if bif ();

  codma_bus_responder #(
    .MEM_DEPTH_WORDS (DEPTH),
    .RD_LATENCY      (RDL),
    .WR_LATENCY      (WRL)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .bus_if     (bif.slave),
    .stall_i    (stall),
    .bd_we_i    (bd_we),
    .bd_addr_i  (bd_addr),
    .bd_wdata_i (bd_wdata),
    .rd_count_o (rd_cnt),
    .wr_count_o (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we    = 1'b1;
    bd_addr  = a;
    bd_wdata = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    model[(a >> 2) % DEPTH] = d;
  endtask

  task automatic drop_bus();
    bif.read_valid  = 1'b0;
    bif.write_valid = 1'b0;
    bif.addr        = '0;
    bif.size        = '0;
    bif.write_data  = '0;
  endtask

  // Issues one request, predicts its response, and checks it when ready arrives.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] sz, input logic [7:0][31:0] wd,
                        input int stall_at, input int stall_len, input string name);
    exp_t e;
    exp_t got;
    int   nw;
    logic bad;
    bit   seen;
    nw  = (sz <= 4'd3) ? (1 << sz) : 0;
    bad = (sz > 4'd3) || (a[1:0] != 2'b00) || (((a >> 2) + nw) > DEPTH);
    e.is_rd = rd;
    e.err   = bad || (rd && wr);
    e.data  = '0;
    e.lat   = (rd ? RDL : WRL) + 1 + stall_len;
    if (rd && !e.err)
      for (int i = 0; i < nw; i++) e.data[i] = model[(a >> 2) + i];
    if (!rd && !e.err)
      for (int i = 0; i < nw; i++) model[(a >> 2) + i] = wd[i];
    sb.push_back(e);

    bif.read_valid  = rd;
    bif.write_valid = wr;
    bif.addr        = a;
    bif.size        = sz;
    bif.write_data  = wd;
    seen = 1'b0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(posedge clk); #1;
      stall = (n >= stall_at) && (n < stall_at + stall_len);
      if (bif.read_ready || bif.write_ready) begin
        seen = 1'b1;
        got  = sb.pop_front();
        checks++;
        if ((n - 1) !== got.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d cycles, expected %0d", name, n - 1, got.lat);
        end
        checks++;
        if ({bif.read_ready, bif.write_ready} !== {got.is_rd, !got.is_rd}) begin
          errors++;
          $display("FAIL %s ready_kind: got rd=%b wr=%b, expected rd=%b", name,
                   bif.read_ready, bif.write_ready, got.is_rd);
        end
        checks++;
        if (bif.error !== got.err) begin
          errors++;
          $display("FAIL %s error: got %b, expected %b", name, bif.error, got.err);
        end
        checks++;
        if (bif.read_data !== got.data) begin
          errors++;
          $display("FAIL %s read_data: got %h, expected %h", name, bif.read_data, got.data);
        end
        if (got.is_rd) exp_rd++;
        else exp_wr++;
        checks++;
        if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin
          errors++;
          $display("FAIL %s counters: got rd=%0d wr=%0d, expected rd=%0d wr=%0d", name,
                   rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
      end
    end
    stall = 1'b0;
    drop_bus();
    if (!seen) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $display("FAIL %s timeout: no ready within 60 cycles, expected after %0d", name, e.lat);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.read_ready || bif.write_ready || bif.error || bif.read_data != '0) begin
      errors++;
      $display("FAIL %s pulse_end: got rr=%b wr=%b err=%b, expected all 0", name,
               bif.read_ready, bif.write_ready, bif.error);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drop_bus();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.read_ready !== 1'b0 || bif.write_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got rr=%b wr=%b, expected 0 0", bif.read_ready, bif.write_ready);
    end
    checks++;
    if (bif.error !== 1'b0 || bif.read_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got err=%b data=%h, expected 0", bif.error, bif.read_data);
    end
    checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got rd=%0d wr=%0d, expected 0 0", rd_cnt, wr_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_burst_read();
    for (int i = 0; i < 16; i++) bd_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    do_txn(1'b1, 1'b0, 32'h100, 4'd3, '0, 0, 0, "read8");
    do_txn(1'b1, 1'b0, 32'h104, 4'd0, '0, 0, 0, "read1");
  endtask

  task automatic test_write_then_read();
    logic [7:0][31:0] wd;
    for (int i = 0; i < 4; i++) bd_write(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
    wd    = '0;
    wd[0] = 32'h11;
    wd[1] = 32'h22;
    wd[2] = 32'hDEAD_BEEF;
    do_txn(1'b0, 1'b1, 32'h200, 4'd1, wd, 0, 0, "write2");
    do_txn(1'b1, 1'b0, 32'h200, 4'd2, '0, 0, 0, "readback4");
  endtask

  task automatic test_errors();
    logic [7:0][31:0] wd;
    for (int i = 0; i < 8; i++) bd_write(32'hFE0 + 32'(4 * i), 32'hC0 + 32'(i));
    do_txn(1'b1, 1'b0, 32'hFE0, 4'd3, '0, 0, 0, "top_edge_ok");
    do_txn(1'b1, 1'b0, 32'hFF0, 4'd3, '0, 0, 0, "overflow");
    do_txn(1'b1, 1'b0, 32'h100, 4'd5, '0, 0, 0, "bad_size");
    do_txn(1'b1, 1'b0, 32'h102, 4'd0, '0, 0, 0, "misaligned");
    wd    = '0;
    wd[0] = 32'h5A5A;
    do_txn(1'b0, 1'b1, 32'h102, 4'd0, wd, 0, 0, "wr_misaligned");
    do_txn(1'b1, 1'b0, 32'h100, 4'd1, '0, 0, 0, "after_bad_wr");
  endtask

  task automatic test_stall();
    do_txn(1'b1, 1'b0, 32'h108, 4'd1, '0, 2, 4, "stall_rd");
    do_txn(1'b0, 1'b1, 32'h10C, 4'd0, '0, 1, 3, "stall_wr");
  endtask

  task automatic test_collision();
    logic [7:0][31:0] wd;
    wd = '0;
    for (int i = 0; i < 8; i++) wd[i] = 32'hF00D_0000 + 32'(i);
    do_txn(1'b1, 1'b1, 32'h110, 4'd1, wd, 0, 0, "rd_wr_both");
    do_txn(1'b1, 1'b0, 32'h110, 4'd1, '0, 0, 0, "after_both");
  endtask

  task automatic test_reset_mid_write();
    bit stray;
    bd_write(32'h300, 32'h77);
    bif.write_valid   = 1'b1;
    bif.addr          = 32'h300;
    bif.size          = 4'd0;
    bif.write_data    = '0;
    bif.write_data[0] = 32'h55;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drop_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_counters: got rd=%0d wr=%0d, expected 0 0", rd_cnt, wr_cnt);
    end
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bif.write_ready || bif.read_ready) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL midreset_no_ready: got a ready pulse, expected none");
    end
    do_txn(1'b1, 1'b0, 32'h300, 4'd0, '0, 0, 0, "midreset_read");
  endtask

  task automatic test_back_to_back();
    logic [7:0][31:0] wd;
    logic             rd;
    logic [3:0]       sz;
    int               off;
    for (int k = 0; k < 10; k++) begin
      rd  = 1'($urandom_range(0, 1));
      sz  = 4'($urandom_range(0, 3));
      off = $urandom_range(0, 16 - (1 << sz));
      for (int i = 0; i < 8; i++) wd[i] = $urandom;
      do_txn(rd, !rd, 32'h100 + 32'(4 * off), sz, wd, 0, 0, "b2b");
    end
  endtask

  initial begin
    drop_bus();
    test_reset();
    test_burst_read();
    test_write_then_read();
    test_errors();
    test_stall();
    test_collision();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
